// File: rtl/s27_resp_sig.sv
// Signature compactor for the s27 G17 response stream: an LFSR-style MISR over fixed-length windows.
// Optional golden-signature compare is built only when S27_RESP_CMP_EN is defined.
module s27_resp_sig #(
  parameter int unsigned       SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0]  SEED    = SIG_W'(16'hFFFF),
  parameter int unsigned       WIN_LEN = 64,
  parameter logic [SIG_W-1:0]  GOLDEN  = SIG_W'(16'h0000)
) (
  input  logic                               CK,
  input  logic                               RST,
  input  logic                               start,
  input  logic                               g17,
  input  logic                               g17_vld,
  output logic                               busy,
  output logic                               done,
  output logic [SIG_W-1:0]                   sig,
  output logic [$clog2(WIN_LEN+1)-1:0]       cnt,
  output logic                               pass
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [SIG_W-1:0]   r_sig;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;

  logic               w_fb;
  logic [SIG_W-1:0]   w_sig_next;
  logic               w_last;

  // One shift of the signature register folding in the current response bit.
  assign w_fb       = r_sig[SIG_W-1] ^ g17;
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
  assign w_last     = (r_cnt == CNT_W'(WIN_LEN - 1));

`ifdef S27_RESP_CMP_EN
  logic r_pass;
`endif

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef S27_RESP_CMP_EN
      r_pass  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_RUN;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef S27_RESP_CMP_EN
            r_pass  <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          // Unqualified cycles leave the window untouched.
          if (g17_vld) begin
            r_sig <= w_sig_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
`ifdef S27_RESP_CMP_EN
              r_pass  <= (w_sig_next == GOLDEN);
`endif
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sig  = r_sig;
  assign cnt  = r_cnt;

`ifdef S27_RESP_CMP_EN
  assign pass = r_pass;
`else
  logic w_unused_golden;
  assign w_unused_golden = ^GOLDEN;
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_s27_resp_sig.sv
// Directed bench for s27_resp_sig (WIN_LEN=8); expected pass depends on S27_RESP_CMP_EN.
module tb_s27_resp_sig;

  localparam int unsigned SIG_W   = 16;
  localparam int unsigned WIN_LEN = 8;
  localparam int unsigned CNT_W   = $clog2(WIN_LEN + 1);
`ifdef S27_RESP_CMP_EN
  localparam logic CMP = 1'b1;
`else
  localparam logic CMP = 1'b0;
`endif

  logic             CK;
  logic             RST;
  logic             start;
  logic             g17;
  logic             g17_vld;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] cnt;
  logic             pass;

  int vectors;
  int miscompares;

  s27_resp_sig #(
    .SIG_W   (SIG_W),
    .POLY    (16'h1021),
    .SEED    (16'hFFFF),
    .WIN_LEN (WIN_LEN),
    .GOLDEN  (16'hE1F0)
  ) dut (
    .CK      (CK),
    .RST     (RST),
    .start   (start),
    .g17     (g17),
    .g17_vld (g17_vld),
    .busy    (busy),
    .done    (done),
    .sig     (sig),
    .cnt     (cnt),
    .pass    (pass)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic bit_in);
    g17     = bit_in;
    g17_vld = 1'b1;
    tick();
    g17_vld = 1'b0;
    g17     = 1'b0;
  endtask

  initial begin
    logic [12:0] mask;
    vectors     = 0;
    miscompares = 0;
    RST = 1'b0; start = 1'b0; g17 = 1'b0; g17_vld = 1'b0;

    // Reset state
    #3 RST = 1'b1;
    tick(); tick();
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_sig",  sig,       16'h0000);
    check("rst_cnt",  16'(cnt),  16'h0);
    check("rst_pass", 16'(pass), 16'h0);
    RST = 1'b0;
    tick();

    // Window of 8 zero samples
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_start_busy", 16'(busy), 16'h1);
    check("a_start_sig",  sig,       16'hFFFF);
    check("a_start_cnt",  16'(cnt),  16'h0);
    for (int i = 0; i < 7; i++) sample(1'b0);
    check("a_7_cnt",  16'(cnt),  16'h7);
    check("a_7_done", 16'(done), 16'h0);
    sample(1'b0);
    check("a_done",      16'(done), 16'h1);
    check("a_done_busy", 16'(busy), 16'h0);
    check("a_sig",       sig,       16'hE1F0);
    check("a_cnt",       16'(cnt),  16'h8);
    check("a_pass",      16'(pass), 16'(CMP));
    tick();
    check("a_done_fall", 16'(done), 16'h0);
    check("a_hold_sig",  sig,       16'hE1F0);
    check("a_hold_cnt",  16'(cnt),  16'h8);
    check("a_hold_pass", 16'(pass), 16'(CMP));
    // Qualified samples in IDLE are ignored
    sample(1'b1);
    check("idle_ign_sig",  sig,       16'hE1F0);
    check("idle_ign_cnt",  16'(cnt),  16'h8);
    check("idle_ign_busy", 16'(busy), 16'h0);

    // Same window with 5 scattered gaps; g17 toggles during gaps
    mask  = 13'b1010110101101;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      g17_vld = mask[i];
      g17     = ~mask[i];
      tick();
      if (i < 12) check("b_no_done", 16'(done), 16'h0);
    end
    g17_vld = 1'b0; g17 = 1'b0;
    check("b_done", 16'(done), 16'h1);
    check("b_sig",  sig,       16'hE1F0);
    check("b_cnt",  16'(cnt),  16'h8);
    check("b_pass", 16'(pass), 16'(CMP));
    tick();

    // One g17=1 sample alters the signature
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c_pass_clr", 16'(pass), 16'h0);
    sample(1'b1);
    check("c_1_sig", sig, 16'hFFFE);
    for (int i = 0; i < 7; i++) sample(1'b0);
    check("c_done", 16'(done), 16'h1);
    check("c_sig",  sig,       16'h7078);
    check("c_pass", 16'(pass), 16'h0);
    tick();

    // Asynchronous reset mid-window
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) sample(1'b0);
    check("d_4_sig", sig,      16'h0E1F);
    check("d_4_cnt", 16'(cnt), 16'h4);
    #2 RST = 1'b1;
    #1;
    check("d_rst_busy", 16'(busy), 16'h0);
    check("d_rst_sig",  sig,       16'h0000);
    check("d_rst_cnt",  16'(cnt),  16'h0);
    g17_vld = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    tick();
    g17_vld = 1'b0;
    check("d_no_resume_busy", 16'(busy), 16'h0);
    check("d_no_resume_done", 16'(done), 16'h0);
    check("d_no_resume_cnt",  16'(cnt),  16'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) sample(1'b0);
    check("d_done", 16'(done), 16'h1);
    check("d_sig",  sig,       16'hE1F0);
    tick();

    // start held high throughout RUN and DONE
    start = 1'b1;
    tick();
    check("e_busy", 16'(busy), 16'h1);
    for (int i = 0; i < 4; i++) sample(1'b0);
    check("e_mid_sig", sig,      16'h0E1F);
    check("e_mid_cnt", 16'(cnt), 16'h4);
    for (int i = 0; i < 4; i++) sample(1'b0);
    check("e_done", 16'(done), 16'h1);
    check("e_sig",  sig,       16'hE1F0);
    check("e_pass", 16'(pass), 16'(CMP));
    tick();
    check("e_done_single", 16'(done), 16'h0);
    check("e_idle_busy",   16'(busy), 16'h0);
    check("e_idle_sig",    sig,       16'hE1F0);
    tick();
    check("e_restart_busy", 16'(busy), 16'h1);
    check("e_restart_sig",  sig,       16'hFFFF);
    check("e_restart_cnt",  16'(cnt),  16'h0);
    check("e_restart_pass", 16'(pass), 16'h0);
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s27_resp_sig.md
S27_RESP_SIG -- requirements
Module: s27_resp_sig

Interface
REQ-001 SHALL have parameter SIG_W, default 16: signature register width, at least 2.
REQ-002 SHALL have parameter POLY, default 16'h1021: feedback polynomial, low SIG_W bits used.
REQ-003 SHALL have parameter SEED, default 16'hFFFF: signature value loaded on start.
REQ-004 SHALL have parameter WIN_LEN, default 64: number of qualified G17 samples per window, at least 1.
REQ-005 SHALL have parameter GOLDEN, default 16'h0000: expected signature, used only under S27_RESP_CMP_EN.
REQ-006 SHALL have port CK, input, 1: sole clock, rising edge.
REQ-007 SHALL have port RST, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: window start request.
REQ-009 SHALL have port g17, input, 1: response bit from the s27 G17 output.
REQ-010 SHALL have port g17_vld, input, 1: qualifies g17 in the current cycle.
REQ-011 SHALL have port busy, output, 1: high while in RUN.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at window end.
REQ-013 SHALL have port sig, output, SIG_W: current signature.
REQ-014 SHALL have port cnt, output, clog2(WIN_LEN+1): number of samples taken in the current window.
REQ-015 SHALL have port pass, output, 1: signature-match flag.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE, all outputs registered.
- IDLE to RUN: start=1. Same edge: sig<=SEED, cnt<=0.
- RUN to DONE: the edge consuming the WIN_LEN-th qualified sample.
- DONE to IDLE: unconditionally on the next edge.
REQ-017 SHALL, in RUN with g17_vld=1, update the signature as fb=sig[SIG_W-1]^g17, then sig<={sig[SIG_W-2:0],1'b0}^(fb?POLY:0), and increment cnt.
REQ-018 SHALL, in RUN with g17_vld=0, hold sig and cnt; gaps do not alter the result.
REQ-019 SHALL ignore g17 and g17_vld in IDLE and DONE.
REQ-020 SHALL ignore start in RUN and DONE; start is accepted only in IDLE.
REQ-021 SHALL drive busy=1 exactly while the state is RUN.
REQ-022 SHALL drive done=1 exactly while the state is DONE, giving a single cycle.
REQ-023 SHALL give a latency of one edge from the last qualified sample to done=1, with the final sig already visible in that cycle.
REQ-024 SHALL hold sig, cnt and pass after DONE until the next accepted start.
REQ-025 SHALL, when WIN_LEN=1, enter DONE after the first qualified sample.
REQ-026 SHALL leave cnt equal to WIN_LEN at DONE, with no wrap inside a window.

Reset
REQ-027 SHALL, on RST=1 (asynchronous, at any time including mid-RUN), force state=IDLE, sig=0, cnt=0, busy=0, done=0, pass=0.
REQ-028 SHALL discard a partial window on reset and not resume it.
REQ-029 SHALL deassert RST synchronously to CK, as required of the integrator; no start is accepted in the cycle RST falls.

Configuration
REQ-030 SHALL, with S27_RESP_CMP_EN defined, register pass on entry to DONE as (sig_final==GOLDEN[SIG_W-1:0]) and clear it to 0 on an accepted start.
REQ-031 SHALL, without S27_RESP_CMP_EN, tie pass to constant 0, instantiate no comparator, and ignore GOLDEN.

Verification
REQ-032 SHALL cover: defaults, WIN_LEN=8, start pulse, 8 cycles of g17=0 with g17_vld=1 -> done pulses on the edge after the 8th sample, sig=16'hE1F0, cnt=8, busy low from that edge.
REQ-033 SHALL cover: the REQ-032 stimulus with g17_vld low for 5 scattered cycles between samples -> identical sig=16'hE1F0, with done delayed by exactly 5 cycles.
REQ-034 SHALL cover: S27_RESP_CMP_EN, GOLDEN=16'hE1F0, REQ-032 stimulus -> pass=1 at done; a repeat with one g17=1 sample -> pass=0 and sig!=16'hE1F0.
REQ-035 SHALL cover: RST asserted after 4 of 8 samples -> immediate IDLE, sig=0, cnt=0, no done; a new start followed by 8 zeros -> sig=16'hE1F0.
REQ-036 SHALL cover: start held high through RUN and DONE -> window unaffected and done a single cycle; with start still high, a new window begins in IDLE the cycle after DONE.
REQ-037 SHALL cover: macro undefined -> pass=0 throughout every scenario above.
